// File: rtl/riscv_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_dsp_pkg
// Description : Shared widths, types and helpers for the execute/DSP
//               write-back path, the register file and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_dsp_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // One buffered DSP result; kill marks it as superseded by a younger ALU write
    typedef struct packed {
        reg_addr_t rd;
        xlen_t     data;
        logic      kill;
    } wb_entry_t;

    // x0 is hard-wired, so writes to it never matter for hazards or kills
    function automatic logic addr_live(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage : riscv_dsp_pkg
`default_nettype wire

// File: rtl/wb_pending_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_pending_match
// Description : Per-entry match of queued {rd, valid, kill} against a single
//               register address. An entry hits when it is valid, not killed
//               and targets the address.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pending_match
    import riscv_dsp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd,
    input  logic [DEPTH-1:0]                 entry_valid,
    input  logic [DEPTH-1:0]                 entry_kill,
    input  logic [REG_ADDR_W-1:0]            addr,
    output logic [DEPTH-1:0]                 hit
);

    // Fully parallel compare: every entry is checked in the same cycle
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign hit[g] = entry_valid[g] && !entry_kill[g] && (entry_rd[g] == addr);
    end

endmodule : wb_pending_match
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Merges single-cycle ALU results and buffered DSP results onto
//               the single register-file write port. ALU has priority, stale
//               DSP results are killed by younger ALU writes to the same rd,
//               and a starvation guard periodically stalls the ALU so the
//               DSP queue drains. Also reports RAW write-pending flags.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
    import riscv_dsp_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [REG_ADDR_W-1:0]      alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic                       alu_stall,
    input  logic                       dsp_valid,
    output logic                       dsp_ready,
    input  logic [REG_ADDR_W-1:0]      dsp_rd,
    input  logic [XLEN-1:0]            dsp_data,
    output logic                       rf_we,
    output logic [REG_ADDR_W-1:0]      rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    input  logic [REG_ADDR_W-1:0]      raddr1,
    input  logic [REG_ADDR_W-1:0]      raddr2,
    output logic                       pend1,
    output logic                       pend2,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    // Queue storage: kill/valid are flat vectors so all entries can be updated at once
    logic [DEPTH-1:0][REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]                  r_data [DEPTH];
    logic [DEPTH-1:0]                 r_kill;
    logic [DEPTH-1:0]                 r_valid;
    logic [PTR_W-1:0]                 r_wptr;
    logic [PTR_W-1:0]                 r_rptr;
    logic [CNT_W-1:0]                 r_count;

    logic [WAIT_W-1:0]                r_wait;
    logic                             r_stall;

    logic                             r_we;
    logic [REG_ADDR_W-1:0]            r_waddr;
    logic [XLEN-1:0]                  r_wdata;

    logic                             w_alu_grant;
    logic                             w_pop;
    logic                             w_push;
    logic                             w_alu_kill;
    logic                             w_push_kill;
    logic                             w_empty;
    wb_entry_t                        w_head;
    logic [DEPTH-1:0]                 w_kill_hit;
    logic [DEPTH-1:0]                 w_hit1;
    logic [DEPTH-1:0]                 w_hit2;

    assign w_empty     = (r_count == '0);
    assign dsp_ready   = (r_count != CNT_W'(DEPTH));

    // ALU wins whenever it is not being held off; otherwise drain the queue head
    assign w_alu_grant = alu_valid && !r_stall;
    assign w_pop       = !w_alu_grant && !w_empty;

    // rd==0 results complete the handshake but are dropped
    assign w_push      = dsp_valid && dsp_ready && addr_live(dsp_rd);

    // A granted ALU write supersedes every older pending write to the same rd,
    // including a DSP result arriving in this very cycle
    assign w_alu_kill  = w_alu_grant && addr_live(alu_rd);
    assign w_push_kill = w_alu_kill && (dsp_rd == alu_rd);

    assign w_head      = '{rd: r_rd[r_rptr], data: r_data[r_rptr], kill: r_kill[r_rptr]};

    wb_pending_match #(.DEPTH(DEPTH)) u_kill_match (
        .entry_rd    (r_rd),
        .entry_valid (r_valid),
        .entry_kill  (r_kill),
        .addr        (alu_rd),
        .hit         (w_kill_hit)
    );

    wb_pending_match #(.DEPTH(DEPTH)) u_pend1_match (
        .entry_rd    (r_rd),
        .entry_valid (r_valid),
        .entry_kill  (r_kill),
        .addr        (raddr1),
        .hit         (w_hit1)
    );

    wb_pending_match #(.DEPTH(DEPTH)) u_pend2_match (
        .entry_rd    (r_rd),
        .entry_valid (r_valid),
        .entry_kill  (r_kill),
        .addr        (raddr2),
        .hit         (w_hit2)
    );

    // Queue: kill marking, pop at the read pointer, push at the write pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_kill  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_kill && w_kill_hit[i]) begin
                    r_kill[i] <= 1'b1;
                end
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_rd[r_wptr]    <= dsp_rd;
                r_data[r_wptr]  <= dsp_data;
                r_kill[r_wptr]  <= w_push_kill;
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation guard: a head left waiting MAX_WAIT cycles forces one ALU stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_stall <= 1'b0;
            if (!w_empty && !w_pop) begin
                if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
                    r_wait  <= '0;
                    r_stall <= 1'b1;
                end else begin
                    r_wait  <= r_wait + 1'b1;
                end
            end else begin
                r_wait <= '0;
            end
        end
    end

    // Register-file write port, one cycle after the grant or pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_alu_grant) begin
            r_we    <= addr_live(alu_rd);
            r_waddr <= alu_rd;
            r_wdata <= alu_data;
        end else if (w_pop) begin
            r_we    <= !w_head.kill;
            r_waddr <= w_head.rd;
            r_wdata <= w_head.data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    // The write in flight on rf_* lands only at the end of this cycle, so it still counts
    assign pend1 = addr_live(raddr1) && ((r_we && (r_waddr == raddr1)) || (|w_hit1));
    assign pend2 = addr_live(raddr2) && ((r_we && (r_waddr == raddr2)) || (|w_hit2));

    assign alu_stall = r_stall;
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign q_count   = r_count;

endmodule : writeback_arbiter
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed self-checking bench for writeback_arbiter
//               (DEPTH=4, MAX_WAIT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        dsp_valid;
    logic        dsp_ready;
    logic [4:0]  dsp_rd;
    logic [31:0] dsp_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        pend1;
    logic        pend2;
    logic [2:0]  q_count;

    int checks   = 0;
    int failures = 0;

    writeback_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .dsp_valid (dsp_valid),
        .dsp_ready (dsp_ready),
        .dsp_rd    (dsp_rd),
        .dsp_data  (dsp_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .pend1     (pend1),
        .pend2     (pend2),
        .q_count   (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        dsp_valid = 1'b0; dsp_rd = '0; dsp_data = '0; raddr1 = '0; raddr2 = '0;
        tick();
        tick();
        chk("rst_q_count",   32'(q_count),   32'd0);
        chk("rst_dsp_ready", 32'(dsp_ready), 32'd1);
        chk("rst_rf_we",     32'(rf_we),     32'd0);
        chk("rst_alu_stall", 32'(alu_stall), 32'd0);
        chk("rst_rf_waddr",  32'(rf_waddr),  32'd0);
        chk("rst_rf_wdata",  rf_wdata,       32'd0);
        rst = 1'b0;

        // 1: ALU write, then ALU write to x0
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; raddr1 = 5'd5;
        tick();
        chk("t1_we",    32'(rf_we),    32'd1);
        chk("t1_waddr", 32'(rf_waddr), 32'd5);
        chk("t1_wdata", rf_wdata,      32'hDEADBEEF);
        chk("t1_pend1", 32'(pend1),    32'd1);
        alu_rd = 5'd0; alu_data = 32'h1234;
        tick();
        chk("t1_x0_we",  32'(rf_we), 32'd0);
        chk("t1_pend1b", 32'(pend1), 32'd0);
        alu_valid = 1'b0;

        // 2: back-to-back DSP results drain in order
        dsp_valid = 1'b1; dsp_rd = 5'd3; dsp_data = 32'h11;
        tick();
        chk("t2_cnt1", 32'(q_count), 32'd1);
        chk("t2_we0",  32'(rf_we),   32'd0);
        dsp_rd = 5'd4; dsp_data = 32'h22;
        tick();
        chk("t2_we_a",    32'(rf_we),    32'd1);
        chk("t2_waddr_a", 32'(rf_waddr), 32'd3);
        chk("t2_wdata_a", rf_wdata,      32'h11);
        chk("t2_cnt_a",   32'(q_count),  32'd1);
        dsp_valid = 1'b0;
        tick();
        chk("t2_we_b",    32'(rf_we),    32'd1);
        chk("t2_waddr_b", 32'(rf_waddr), 32'd4);
        chk("t2_wdata_b", rf_wdata,      32'h22);
        chk("t2_cnt_b",   32'(q_count),  32'd0);

        // 3: younger ALU write kills the queued DSP result to the same rd
        dsp_valid = 1'b1; dsp_rd = 5'd7; dsp_data = 32'hAA; raddr1 = 5'd7;
        tick();
        chk("t3_cnt1",  32'(q_count), 32'd1);
        chk("t3_we0",   32'(rf_we),   32'd0);
        chk("t3_pend1", 32'(pend1),   32'd1);
        dsp_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hBB;
        tick();
        chk("t3_we",     32'(rf_we),    32'd1);
        chk("t3_waddr",  32'(rf_waddr), 32'd7);
        chk("t3_wdata",  rf_wdata,      32'hBB);
        chk("t3_cnt",    32'(q_count),  32'd1);
        chk("t3_pend1b", 32'(pend1),    32'd1);
        alu_valid = 1'b0;
        tick();
        chk("t3_kill_we", 32'(rf_we),   32'd0);
        chk("t3_cnt0",    32'(q_count), 32'd0);
        chk("t3_pend1c",  32'(pend1),   32'd0);

        // 5: same-cycle ALU and DSP to rd 9, ALU wins
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        dsp_valid = 1'b1; dsp_rd = 5'd9; dsp_data = 32'h55; raddr2 = 5'd9;
        tick();
        chk("t5_we",    32'(rf_we),    32'd1);
        chk("t5_waddr", 32'(rf_waddr), 32'd9);
        chk("t5_wdata", rf_wdata,      32'h99);
        chk("t5_cnt",   32'(q_count),  32'd1);
        chk("t5_pend2", 32'(pend2),    32'd1);
        alu_valid = 1'b0; dsp_valid = 1'b0;
        tick();
        chk("t5_kill_we", 32'(rf_we),   32'd0);
        chk("t5_cnt0",    32'(q_count), 32'd0);
        chk("t5_pend2b",  32'(pend2),   32'd0);

        // 4: ALU busy every cycle fills the queue, starvation guard fires
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
        dsp_valid = 1'b1; dsp_rd = 5'd10; dsp_data = 32'h1010;
        raddr1 = 5'd11; raddr2 = 5'd12;
        tick();                                     // G0: entry 10
        chk("t4_cnt_g0", 32'(q_count), 32'd1);
        dsp_rd = 5'd11; dsp_data = 32'h1011;
        tick();                                     // G1
        dsp_rd = 5'd12; dsp_data = 32'h1012;
        tick();                                     // G2
        chk("t4_cnt_g2",   32'(q_count),   32'd3);
        chk("t4_ready_g2", 32'(dsp_ready), 32'd1);
        dsp_rd = 5'd13; dsp_data = 32'h1013;
        tick();                                     // G3: full
        chk("t4_cnt_g3",   32'(q_count),   32'd4);
        chk("t4_ready_g3", 32'(dsp_ready), 32'd0);
        dsp_rd = 5'd14; dsp_data = 32'h1014;
        for (int k = 4; k <= 7; k++) begin
            tick();                                 // G4..G7
            chk("t4_nostall", 32'(alu_stall), 32'd0);
            chk("t4_cnt_full", 32'(q_count), 32'd4);
        end
        tick();                                     // G8
        chk("t4_stall_g8", 32'(alu_stall), 32'd1);
        chk("t4_alu_we",   32'(rf_we),     32'd1);
        chk("t4_alu_addr", 32'(rf_waddr),  32'd1);
        dsp_valid = 1'b0;
        tick();                                     // G9: head drains
        chk("t4_stall_g9", 32'(alu_stall), 32'd0);
        chk("t4_pop_we",   32'(rf_we),     32'd1);
        chk("t4_pop_addr", 32'(rf_waddr),  32'd10);
        chk("t4_pop_data", rf_wdata,       32'h1010);
        chk("t4_cnt_g9",   32'(q_count),   32'd3);
        chk("t4_ready_g9", 32'(dsp_ready), 32'd1);
        chk("t4_pend1",    32'(pend1),     32'd1);
        chk("t4_pend2",    32'(pend2),     32'd1);

        // 6: reset with 3 entries queued
        alu_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cnt",   32'(q_count),   32'd0);
        chk("t6_we",    32'(rf_we),     32'd0);
        chk("t6_ready", 32'(dsp_ready), 32'd1);
        chk("t6_stall", 32'(alu_stall), 32'd0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            chk("t6_pend1", 32'(pend1), 32'd0);
            chk("t6_pend2", 32'(pend2), 32'd0);
        end

        // DSP result to x0: handshake completes, nothing enqueued
        dsp_valid = 1'b1; dsp_rd = 5'd0; dsp_data = 32'hCAFE;
        tick();
        chk("x0_cnt",   32'(q_count),   32'd0);
        chk("x0_ready", 32'(dsp_ready), 32'd1);
        dsp_valid = 1'b0;
        tick();
        chk("x0_we", 32'(rf_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_writeback_arbiter
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Merges single-cycle ALU results and variable-latency DSP/MAC results onto the single register-file write port (we/waddr/wdata).
- Sits between the execute stage, the DSP unit and the register file.
- Buffers DSP results in a small queue and gives the ALU priority.
- Kills stale DSP results that a younger ALU write to the same rd would otherwise overwrite.
- Reports per-operand "write pending" flags so decode can stall on RAW hazards.

Parameters:
- DEPTH, 4: DSP result queue entries (power of 2, ≥2).
- MAX_WAIT, 8: cycles a live queue head may wait before the ALU is forced to stall.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- alu_stall  out  1  registered: upstream must hold its ALU result this cycle; arbiter ignores alu_valid.
- dsp_valid  in  1  DSP result offered.
- dsp_ready  out  1  queue can accept.
- dsp_rd  in  5  DSP destination.
- dsp_data  in  32  DSP result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- raddr1, raddr2  in  5  decode operand addresses.
- pend1, pend2  out  1  a write to raddrN is still outstanding.
- q_count  out  $clog2(DEPTH+1)  queue occupancy, killed entries included.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - Clears the queue, kill bits, wait counter, alu_stall and rf_we.
  - rf_waddr and rf_wdata go to 0.
  - Any queued DSP results are discarded.
  - dsp_ready is 1 from the first cycle after reset.
- dsp_ready = (q_count != DEPTH), purely from state. DSP accept = dsp_valid && dsp_ready.
- DSP accept with dsp_rd==0: the handshake completes but nothing is enqueued.
- Each queue entry holds {rd, data, kill}.
- Arbitration, evaluated each cycle:
  - alu_grant = alu_valid && !alu_stall.
  - Otherwise, if the queue is non-empty, the head is popped.
- Output register (rf_* is registered):
  - alu_grant in cycle N: rf_we=(alu_rd!=0), rf_waddr=alu_rd, rf_wdata=alu_data in cycle N+1.
  - Head popped in cycle N: rf_we=!head.kill, with head rd/data, in cycle N+1.
  - Neither: rf_we=0, and rf_waddr/rf_wdata hold their values.
  - Latency is therefore exactly 1 cycle from grant.
- Stale-write kill:
  - On alu_grant with alu_rd!=0, every queued entry with rd==alu_rd sets kill=1. This includes the head being popped in the same cycle; if the ALU wins, the head is not popped.
  - A DSP result accepted in the same cycle with dsp_rd==alu_rd is enqueued with kill=1. The DSP op is older, so the ALU wins.
  - Killed entries still occupy the queue and drain normally with rf_we=0.
- Simultaneous push and pop:
  - Allowed; q_count is unchanged.
  - A push into a full queue is impossible because dsp_ready=0.
  - Read and write pointers wrap modulo DEPTH.
- Starvation guard:
  - wait_cnt increments on each cycle the queue is non-empty and no pop occurs; it clears on a pop or when the queue is empty.
  - When wait_cnt reaches MAX_WAIT-1 with no pop that cycle, alu_stall=1 in the next cycle and wait_cnt clears.
  - While alu_stall=1 the head pops. alu_stall is 1 for exactly one cycle.
- pend1 (and likewise pend2):
  - Equals (raddr1!=0) && ((rf_we && rf_waddr==raddr1) || any live, non-killed entry with rd==raddr1).
  - The register file writes at the edge ending the rf_we cycle, so that cycle must count as pending.
  - Combinational from state and raddr only.

Decomposition:
- riscv_dsp_pkg: XLEN=32, REG_ADDR_W=5, REG_ZERO=5'd0; shared with the register file and decode.
- Sub-module wb_pending_match: compares DEPTH entries' {rd, valid, kill} against one address and returns the hit. It is instantiated twice for pend1/pend2 and reused for the kill match against alu_rd.
- Queue storage and pointers stay inline, because the kill bits need parallel access to all entries.

Test Plan:
1. ALU only, alu_rd=5, alu_data=0xDEADBEEF → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Then alu_rd=0 → rf_we=0.
2. DSP writes rd=3 data=0x11, rd=4 data=0x22 back-to-back, with ALU idle → rf writes 3/0x11 then 4/0x22 in order, and q_count returns to 0.
3. DSP enqueues rd=7 data=0xAA, then ALU writes rd=7 data=0xBB before the drain → rf sees 7/0xBB only. The killed entry drains with rf_we=0, and pend for addr 7 drops after the ALU write cycle.
4. DEPTH=4 queue with ALU busy every cycle → dsp_ready=0 after 4 accepts. With MAX_WAIT=8, alu_stall=1 for exactly one cycle 8 cycles after the first entry, and one entry drains in the following cycle.
5. Same-cycle ALU rd=9 and DSP accept rd=9 → rf writes 9 with the ALU data. The DSP entry is killed and never written.
6. Reset asserted with 3 entries queued → the next cycle has q_count=0, rf_we=0, dsp_ready=1, alu_stall=0, and pend1=pend2=0 for all addresses.
